// File: rtl/codes.sv
// rtl/codes.sv - state, instruction-field and register-select encodings shared by the MIPS CPU control path
package codes;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    IWAIT = 3'd1,
    EXEC1 = 3'd2,
    DWAIT = 3'd3,
    EXEC2 = 3'd4,
    HALT  = 3'd5
  } state_t;

  typedef enum logic [5:0] {
    OP_R_TYPE = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
    OP_BEQ    = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
    OP_ADDI   = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
    OP_ANDI   = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
    OP_LB     = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24,
    OP_LHU    = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    F_SLL  = 6'h00, F_SRL   = 6'h02, F_SRA  = 6'h03, F_SLLV  = 6'h04,
    F_SRLV = 6'h06, F_SRAV  = 6'h07, F_JR   = 6'h08, F_JALR  = 6'h09,
    F_MFHI = 6'h10, F_MTHI  = 6'h11, F_MFLO = 6'h12, F_MTLO  = 6'h13,
    F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU  = 6'h1B,
    F_ADD  = 6'h20, F_ADDU  = 6'h21, F_SUB  = 6'h22, F_SUBU  = 6'h23,
    F_AND  = 6'h24, F_OR    = 6'h25, F_XOR  = 6'h26, F_NOR   = 6'h27,
    F_SLT  = 6'h2A, F_SLTU  = 6'h2B
  } func_t;

  typedef enum logic [4:0] {
    RI_BLTZ   = 5'h00,
    RI_BGEZ   = 5'h01,
    RI_BLTZAL = 5'h10,
    RI_BGEZAL = 5'h11
  } regimm_t;

  typedef enum logic [1:0] {
    RT    = 2'd0,
    RD    = 2'd1,
    GPR31 = 2'd2
  } regfile_addr_sel_t;

  function automatic logic [3:0] byte_en_for(input logic [5:0] opcode, input logic [1:0] offset);
    logic [3:0] be;
    case (opcode)
      OP_LW, OP_SW:         be = 4'b1111;
      OP_LH, OP_LHU, OP_SH: be = 4'b0011 << offset;
      OP_LB, OP_LBU, OP_SB: be = 4'b0001 << offset;
      default:              be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mips_cpu_read_latency_tracker.sv
// rtl/mips_cpu_read_latency_tracker.sv - counts down from an accepted read and flags the cycle readdata is valid
module mips_cpu_read_latency_tracker #(
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic waiting_i,
  output logic done_o
);

  localparam int CW = 3;
  localparam logic [CW-1:0] LOAD_VAL = CW'(READ_LATENCY - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start_i) begin
      count_d = LOAD_VAL;
    end else if (waiting_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = waiting_i && (count_q == '0);

endmodule

// File: rtl/mips_cpu_sequencer.sv
// rtl/mips_cpu_sequencer.sv - multi-cycle MIPS control sequencer with memory handshake, mult/div stalls and halt
// MIPS_CPU_SEQ_PERF_EN builds saturating cycle and retired-instruction counters.
module mips_cpu_sequencer
  import codes::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              waitrequest_i,
  input  logic [5:0]        opcode_i,
  input  logic [5:0]        function_i,
  input  logic [4:0]        regimm_i,
  input  logic              b_cond_met_i,
  input  logic [1:0]        byte_offset_i,
  input  logic              muldiv_busy_i,
  input  logic              pc_next_zero_i,
  output state_t            state_o,
  output logic              active_o,
  output logic              pc_write_en_o,
  output logic              ir_write_en_o,
  output logic              data_latch_en_o,
  output logic              ram_read_en_o,
  output logic              ram_write_en_o,
  output logic [3:0]        ram_byte_en_o,
  output logic              ram_addr_sel_o,
  output logic              src_b_sel_o,
  output logic              regfile_write_en_o,
  output regfile_addr_sel_t regfile_addr_3_sel_o,
  output logic [31:0]       cycle_count_o,
  output logic [31:0]       instr_count_o
);

  state_t            state_q, state_d;
  logic              is_load, is_store, is_muldiv, is_ialu, rf_wr;
  regfile_addr_sel_t rf_sel;
  logic              lat_start, lat_waiting, lat_done, exit_cycle;

  mips_cpu_read_latency_tracker #(
    .READ_LATENCY(READ_LATENCY)
  ) u_lat (
    .clk      (clk),
    .reset    (reset),
    .start_i  (lat_start),
    .waiting_i(lat_waiting),
    .done_o   (lat_done)
  );

  assign lat_waiting          = (state_q == IWAIT) || (state_q == DWAIT);
  assign state_o              = state_q;
  assign regfile_addr_3_sel_o = rf_sel;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_muldiv = 1'b0;
    is_ialu   = 1'b0;
    rf_wr     = 1'b0;
    rf_sel    = RT;
    case (opcode_i)
      OP_R_TYPE: begin
        case (function_i)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            rf_wr  = 1'b1;
            rf_sel = RD;
          end
          F_MFHI, F_MFLO: begin
            is_muldiv = 1'b1;
            rf_wr     = 1'b1;
            rf_sel    = RD;
          end
          F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: is_muldiv = 1'b1;
          F_JALR: begin
            rf_wr  = b_cond_met_i;
            rf_sel = RD;
          end
          default: ;
        endcase
      end
      // Link variants write the return address whether or not the branch is taken.
      OP_REGIMM: begin
        if ((regimm_i == RI_BLTZAL) || (regimm_i == RI_BGEZAL)) begin
          rf_wr  = 1'b1;
          rf_sel = GPR31;
        end
      end
      OP_JAL: begin
        rf_wr  = b_cond_met_i;
        rf_sel = GPR31;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        is_ialu = 1'b1;
        rf_wr   = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        is_load = 1'b1;
        rf_wr   = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: is_store = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    lat_start          = 1'b0;
    exit_cycle         = 1'b0;
    active_o           = (state_q != HALT);
    pc_write_en_o      = 1'b0;
    ir_write_en_o      = 1'b0;
    data_latch_en_o    = 1'b0;
    ram_read_en_o      = 1'b0;
    ram_write_en_o     = 1'b0;
    ram_byte_en_o      = 4'b0000;
    ram_addr_sel_o     = 1'b0;
    src_b_sel_o        = 1'b0;
    regfile_write_en_o = 1'b0;
    case (state_q)
      FETCH: begin
        ram_read_en_o = 1'b1;
        ram_byte_en_o = 4'b1111;
        if (!waitrequest_i) begin
          lat_start = 1'b1;
          state_d   = IWAIT;
        end
      end
      IWAIT: begin
        if (lat_done) begin
          ir_write_en_o = 1'b1;
          state_d       = EXEC1;
        end
      end
      EXEC1: begin
        if (is_load) begin
          ram_read_en_o  = 1'b1;
          ram_addr_sel_o = 1'b1;
          src_b_sel_o    = 1'b1;
          ram_byte_en_o  = byte_en_for(opcode_i, byte_offset_i);
          if (!waitrequest_i) begin
            lat_start = 1'b1;
            state_d   = DWAIT;
          end
        end else begin
          src_b_sel_o = is_ialu || is_store;
          state_d     = EXEC2;
        end
      end
      DWAIT: begin
        if (lat_done) begin
          data_latch_en_o = 1'b1;
          state_d         = EXEC2;
        end
      end
      EXEC2: begin
        if (is_store) begin
          ram_write_en_o = 1'b1;
          ram_addr_sel_o = 1'b1;
          src_b_sel_o    = 1'b1;
          ram_byte_en_o  = byte_en_for(opcode_i, byte_offset_i);
        end
        exit_cycle = !((is_store && waitrequest_i) || (is_muldiv && muldiv_busy_i));
        if (exit_cycle) begin
          pc_write_en_o      = 1'b1;
          regfile_write_en_o = rf_wr;
          state_d            = pc_next_zero_i ? HALT : FETCH;
        end
      end
      HALT: ;
      default: state_d = FETCH;
    endcase
    if (reset) begin
      state_d            = FETCH;
      lat_start          = 1'b0;
      exit_cycle         = 1'b0;
      active_o           = 1'b0;
      pc_write_en_o      = 1'b0;
      ir_write_en_o      = 1'b0;
      data_latch_en_o    = 1'b0;
      ram_read_en_o      = 1'b0;
      ram_write_en_o     = 1'b0;
      ram_byte_en_o      = 4'b0000;
      ram_addr_sel_o     = 1'b0;
      src_b_sel_o        = 1'b0;
      regfile_write_en_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MIPS_CPU_SEQ_PERF_EN
  logic [31:0] cycle_count_q, cycle_count_d, instr_count_q, instr_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q;
    instr_count_d = instr_count_q;
    if (active_o && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end
    if (exit_cycle && (instr_count_q != '1)) begin
      instr_count_d = instr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cycle_count_o = cycle_count_q;
  assign instr_count_o = instr_count_q;
`else
  assign cycle_count_o = '0;
  assign instr_count_o = '0;
`endif

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// tb/tb_mips_cpu_sequencer.sv - randomized per-instruction timeline model checked cycle by cycle against mips_cpu_sequencer
module tb_mips_cpu_sequencer;
  import codes::*;

  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1, waitrequest_i = 1'b0, b_cond_met_i = 1'b0;
  logic              muldiv_busy_i = 1'b0, pc_next_zero_i = 1'b0;
  logic [5:0]        opcode_i = '0, function_i = '0;
  logic [4:0]        regimm_i = '0;
  logic [1:0]        byte_offset_i = '0;
  state_t            state_o;
  logic              active_o, pc_write_en_o, ir_write_en_o, data_latch_en_o;
  logic              ram_read_en_o, ram_write_en_o, ram_addr_sel_o, src_b_sel_o, regfile_write_en_o;
  logic [3:0]        ram_byte_en_o;
  regfile_addr_sel_t regfile_addr_3_sel_o;
  logic [31:0]       cycle_count_o, instr_count_o;

  mips_cpu_sequencer #(.READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .waitrequest_i(waitrequest_i), .opcode_i(opcode_i),
    .function_i(function_i), .regimm_i(regimm_i), .b_cond_met_i(b_cond_met_i),
    .byte_offset_i(byte_offset_i), .muldiv_busy_i(muldiv_busy_i), .pc_next_zero_i(pc_next_zero_i),
    .state_o(state_o), .active_o(active_o), .pc_write_en_o(pc_write_en_o),
    .ir_write_en_o(ir_write_en_o), .data_latch_en_o(data_latch_en_o),
    .ram_read_en_o(ram_read_en_o), .ram_write_en_o(ram_write_en_o), .ram_byte_en_o(ram_byte_en_o),
    .ram_addr_sel_o(ram_addr_sel_o), .src_b_sel_o(src_b_sel_o),
    .regfile_write_en_o(regfile_write_en_o), .regfile_addr_3_sel_o(regfile_addr_3_sel_o),
    .cycle_count_o(cycle_count_o), .instr_count_o(instr_count_o)
  );

  typedef enum int {C_RALU, C_MDW, C_MD, C_JALR, C_LINK, C_JAL, C_IALU,
                    C_LW, C_LH, C_LB, C_SW, C_SH, C_SB, C_NONE} cls_t;
  typedef struct { logic [5:0] op; logic [5:0] fn; logic [4:0] ri; cls_t cls; } ins_t;
  typedef struct { bit rst; bit wr; bit busy; bit act; bit ex; logic [17:0] exp; logic [17:0] mask; } row_t;

  ins_t        tbl[$];
  row_t        rows[$];
  int          n_checks = 0, n_fail = 0;
  logic [31:0] m_cyc = '0, m_instr = '0;
  bit          perf_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (time %0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic ins_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] ri, input cls_t c);
    ins_t t;
    t.op = op; t.fn = fn; t.ri = ri; t.cls = c;
    return t;
  endfunction

  task automatic push(input bit rst, input bit wr, input bit busy, input state_t st,
                      input bit pcw, input bit irw, input bit dle, input bit rd, input bit wrn,
                      input logic [3:0] be, input bit as, input bit sb, input bit rfw,
                      input regfile_addr_sel_t rfs, input bit ex);
    row_t r;
    r.rst = rst; r.wr = wr; r.busy = busy; r.ex = ex;
    r.act  = !rst && (st != HALT);
    r.exp  = {st, r.act, pcw, irw, dle, rd, wrn, be, as, sb, rfw, rfs};
    r.mask = '1;
    if (rst) r.mask[17:15] = 3'b000;
    if (!rfw) r.mask[1:0] = 2'b00;
    rows.push_back(r);
  endtask

  task automatic push_reset();
    push(1'b1, rnd(), rnd(), FETCH, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, RT, 0);
  endtask

  task automatic play();
    logic [17:0] obs;
    foreach (rows[k]) begin
      reset = rows[k].rst; waitrequest_i = rows[k].wr; muldiv_busy_i = rows[k].busy;
      @(negedge clk);
      obs = {state_o, active_o, pc_write_en_o, ir_write_en_o, data_latch_en_o, ram_read_en_o,
             ram_write_en_o, ram_byte_en_o, ram_addr_sel_o, src_b_sel_o, regfile_write_en_o,
             regfile_addr_3_sel_o};
      check("cycle_outputs", 64'(obs & rows[k].mask), 64'(rows[k].exp & rows[k].mask));
`ifdef MIPS_CPU_SEQ_PERF_EN
      if (perf_valid) check("perf_counts", {cycle_count_o, instr_count_o}, {m_cyc, m_instr});
`else
      check("perf_counts", {cycle_count_o, instr_count_o}, 64'h0);
`endif
      @(posedge clk);
      #1;
      if (rows[k].rst) begin
        m_cyc = '0; m_instr = '0; perf_valid = 1'b1;
      end else begin
        if (rows[k].act && (m_cyc != 32'hFFFF_FFFF)) m_cyc++;
        if (rows[k].ex && (m_instr != 32'hFFFF_FFFF)) m_instr++;
      end
    end
    rows.delete();
  endtask

  task automatic run(input ins_t in, input int fw, input int dw, input int bz, input bit bc,
                     input logic [1:0] off, input bit pcz, input int abort_at);
    bit ld, st, md, aborted, rfw;
    regfile_addr_sel_t rfs;
    logic [3:0] be;
    ld = in.cls inside {C_LW, C_LH, C_LB};
    st = in.cls inside {C_SW, C_SH, C_SB};
    md = in.cls inside {C_MD, C_MDW};
    if (in.cls inside {C_LW, C_SW})      be = 4'hF;
    else if (in.cls inside {C_LH, C_SH}) be = 4'b0011 << off;
    else                                 be = 4'b0001 << off;
    rfs = RT; rfw = 1'b0;
    case (in.cls)
      C_RALU, C_MDW:        begin rfw = 1'b1; rfs = RD; end
      C_JALR:               begin rfw = bc;   rfs = RD; end
      C_LINK:               begin rfw = 1'b1; rfs = GPR31; end
      C_JAL:                begin rfw = bc;   rfs = GPR31; end
      C_IALU, C_LW, C_LH, C_LB: rfw = 1'b1;
      default: ;
    endcase
    opcode_i = in.op; function_i = in.fn; regimm_i = in.ri;
    b_cond_met_i = bc; byte_offset_i = off; pc_next_zero_i = pcz;
    aborted = 1'b0;

    for (int i = 0; i < fw; i++) push(0, 1, rnd(), FETCH, 0, 0, 0, 1, 0, 4'hF, 0, 0, 0, RT, 0);
    push(0, 0, rnd(), FETCH, 0, 0, 0, 1, 0, 4'hF, 0, 0, 0, RT, 0);
    for (int i = 0; i < LAT; i++) push(0, rnd(), rnd(), IWAIT, 0, (i == LAT-1), 0, 0, 0, 4'h0, 0, 0, 0, RT, 0);
    if (ld) begin
      for (int i = 0; i < dw; i++) push(0, 1, rnd(), EXEC1, 0, 0, 0, 1, 0, be, 1, 1, 0, RT, 0);
      push(0, 0, rnd(), EXEC1, 0, 0, 0, 1, 0, be, 1, 1, 0, RT, 0);
      for (int i = 0; i < LAT && !aborted; i++) begin
        if (i == abort_at) begin
          push_reset();
          aborted = 1'b1;
        end else begin
          push(0, rnd(), rnd(), DWAIT, 0, 0, (i == LAT-1), 0, 0, 4'h0, 0, 0, 0, RT, 0);
        end
      end
    end else begin
      push(0, rnd(), rnd(), EXEC1, 0, 0, 0, 0, 0, 4'h0, 0, (in.cls == C_IALU) || st, 0, RT, 0);
    end
    if (!aborted) begin
      if (st) for (int i = 0; i < dw; i++) push(0, 1, rnd(), EXEC2, 0, 0, 0, 0, 1, be, 1, 1, 0, RT, 0);
      if (md) for (int i = 0; i < bz; i++) push(0, rnd(), 1, EXEC2, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, RT, 0);
      push(0, st ? 1'b0 : rnd(), md ? 1'b0 : rnd(), EXEC2, 1, 0, 0, 0, st, st ? be : 4'h0,
           st, st, rfw, rfs, 1);
      if (pcz) begin
        for (int i = 0; i < 3; i++) push(0, rnd(), rnd(), HALT, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, RT, 0);
        push_reset();
      end
    end
    play();
  endtask

  initial begin
    ins_t in;
    bit   ld;
    tbl.push_back(mk(6'h00, 6'h21, 5'h00, C_RALU)); tbl.push_back(mk(6'h00, 6'h00, 5'h00, C_RALU));
    tbl.push_back(mk(6'h00, 6'h22, 5'h00, C_RALU)); tbl.push_back(mk(6'h00, 6'h27, 5'h00, C_RALU));
    tbl.push_back(mk(6'h00, 6'h2B, 5'h00, C_RALU)); tbl.push_back(mk(6'h00, 6'h07, 5'h00, C_RALU));
    tbl.push_back(mk(6'h00, 6'h10, 5'h00, C_MDW));  tbl.push_back(mk(6'h00, 6'h12, 5'h00, C_MDW));
    tbl.push_back(mk(6'h00, 6'h11, 5'h00, C_MD));   tbl.push_back(mk(6'h00, 6'h13, 5'h00, C_MD));
    tbl.push_back(mk(6'h00, 6'h18, 5'h00, C_MD));   tbl.push_back(mk(6'h00, 6'h19, 5'h00, C_MD));
    tbl.push_back(mk(6'h00, 6'h1A, 5'h00, C_MD));   tbl.push_back(mk(6'h00, 6'h1B, 5'h00, C_MD));
    tbl.push_back(mk(6'h00, 6'h08, 5'h00, C_NONE)); tbl.push_back(mk(6'h00, 6'h09, 5'h00, C_JALR));
    tbl.push_back(mk(6'h00, 6'h01, 5'h00, C_NONE)); tbl.push_back(mk(6'h00, 6'h3F, 5'h00, C_NONE));
    tbl.push_back(mk(6'h01, 6'h00, 5'h00, C_NONE)); tbl.push_back(mk(6'h01, 6'h00, 5'h01, C_NONE));
    tbl.push_back(mk(6'h01, 6'h00, 5'h10, C_LINK)); tbl.push_back(mk(6'h01, 6'h00, 5'h11, C_LINK));
    tbl.push_back(mk(6'h01, 6'h00, 5'h05, C_NONE)); tbl.push_back(mk(6'h02, 6'h00, 5'h00, C_NONE));
    tbl.push_back(mk(6'h03, 6'h00, 5'h00, C_JAL));  tbl.push_back(mk(6'h04, 6'h00, 5'h00, C_NONE));
    tbl.push_back(mk(6'h07, 6'h00, 5'h00, C_NONE)); tbl.push_back(mk(6'h08, 6'h00, 5'h00, C_IALU));
    tbl.push_back(mk(6'h09, 6'h00, 5'h00, C_IALU)); tbl.push_back(mk(6'h0B, 6'h00, 5'h00, C_IALU));
    tbl.push_back(mk(6'h0D, 6'h00, 5'h00, C_IALU)); tbl.push_back(mk(6'h0F, 6'h00, 5'h00, C_IALU));
    tbl.push_back(mk(6'h20, 6'h00, 5'h00, C_LB));   tbl.push_back(mk(6'h21, 6'h00, 5'h00, C_LH));
    tbl.push_back(mk(6'h23, 6'h00, 5'h00, C_LW));   tbl.push_back(mk(6'h24, 6'h00, 5'h00, C_LB));
    tbl.push_back(mk(6'h25, 6'h00, 5'h00, C_LH));   tbl.push_back(mk(6'h28, 6'h00, 5'h00, C_SB));
    tbl.push_back(mk(6'h29, 6'h00, 5'h00, C_SH));   tbl.push_back(mk(6'h2B, 6'h00, 5'h00, C_SW));
    tbl.push_back(mk(6'h22, 6'h00, 5'h00, C_NONE)); tbl.push_back(mk(6'h3F, 6'h00, 5'h00, C_NONE));

    #1;
    push_reset();
    push_reset();
    play();

    run(mk(6'h00, 6'h21, 5'h00, C_RALU), 0, 0, 0, 1'b0, 2'd0, 1'b0, -1);
    run(mk(6'h00, 6'h21, 5'h00, C_RALU), 3, 0, 0, 1'b0, 2'd0, 1'b0, -1);
    run(mk(6'h20, 6'h00, 5'h00, C_LB),   0, 0, 0, 1'b0, 2'd2, 1'b0, -1);
    run(mk(6'h29, 6'h00, 5'h00, C_SH),   0, 2, 0, 1'b0, 2'd2, 1'b0, -1);
    run(mk(6'h00, 6'h18, 5'h00, C_MD),   0, 0, 5, 1'b0, 2'd0, 1'b0, -1);
    run(mk(6'h01, 6'h00, 5'h10, C_LINK), 0, 0, 0, 1'b0, 2'd0, 1'b0, -1);
    run(mk(6'h20, 6'h00, 5'h00, C_LB),   1, 1, 0, 1'b0, 2'd1, 1'b0, 1);
    run(mk(6'h00, 6'h08, 5'h00, C_NONE), 0, 0, 0, 1'b0, 2'd0, 1'b1, -1);

    for (int n = 0; n < 150; n++) begin
      in = tbl[$urandom_range(0, tbl.size() - 1)];
      ld = in.cls inside {C_LW, C_LH, C_LB};
      run(in, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5), rnd(),
          2'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0),
          (ld && ($urandom_range(0, 7) == 0)) ? $urandom_range(0, LAT - 1) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_sequencer.md
Name: mips_cpu_sequencer

Overview:
- Owns the multi-cycle instruction state register of the MIPS CPU and drives all datapath and memory control enables.
- Supersedes the combinational control decoder that took its state from outside.
- Adds a memory handshake that honours `waitrequest`, a parametrised read latency, mult/div busy stalls and a halt state.
- Sits between the Avalon-style memory port, the IR/PC registers, the register file and the mult/div unit.

Parameters:
- `READ_LATENCY`, 1, cycles from read acceptance (`ram_read_en_o` & ~`waitrequest_i`) to valid readdata; legal range 1..7.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `waitrequest_i`  in  1  memory not accepting the current read/write
- `opcode_i`  in  6  IR[31:26]
- `function_i`  in  6  IR[5:0]
- `regimm_i`  in  5  IR[20:16]
- `b_cond_met_i`  in  1  branch/jump-link condition from ALU
- `byte_offset_i`  in  2  effective address [1:0]
- `muldiv_busy_i`  in  1  mult/div unit computing
- `pc_next_zero_i`  in  1  next PC equals 0x00000000 (halt request)
- `state_o`  out  state_t  current state
- `active_o`  out  1  CPU running
- `pc_write_en_o`  out  1  PC update
- `ir_write_en_o`  out  1  IR capture
- `data_latch_en_o`  out  1  load-data register capture
- `ram_read_en_o`  out  1  memory read
- `ram_write_en_o`  out  1  memory write
- `ram_byte_en_o`  out  4  byte enables
- `ram_addr_sel_o`  out  1  0 = PC, 1 = ALU address
- `src_b_sel_o`  out  1  0 = rt, 1 = immediate
- `regfile_write_en_o`  out  1  register-file write
- `regfile_addr_3_sel_o`  out  regfile_addr_sel_t  RT / RD / GPR31
- `cycle_count_o`  out  32  see Optional Feature
- `instr_count_o`  out  32  see Optional Feature

Behaviour:
- **Reset.** State becomes FETCH and the latency counter 0 on the next edge. While `reset` is high, every enable output is 0 and `active_o` is 0. Reset in any state, including mid-wait, abandons the instruction.
- **States.** FETCH, IWAIT, EXEC1, DWAIT, EXEC2, HALT. All outputs are decoded combinationally from state, IR fields and inputs. Exactly one memory transaction is outstanding at any time.
- **FETCH.**
  - Drives `ram_read_en_o`=1, `ram_addr_sel_o`=0, `ram_byte_en_o`=1111.
  - Holds while `waitrequest_i`=1.
  - On acceptance, loads counter = `READ_LATENCY`-1 and goes to IWAIT.
- **IWAIT.**
  - Counts down.
  - At counter 0, asserts `ir_write_en_o` for that one cycle only, then goes to EXEC1.
- **EXEC1.**
  - Loads (LW/LH/LHU/LB/LBU):
    - Drives `ram_read_en_o`=1, `ram_addr_sel_o`=1, `src_b_sel_o`=1.
    - Byte enables: LW 1111; halfword 0011<<offset; byte 0001<<offset.
    - Holds under `waitrequest_i`; on acceptance goes to DWAIT.
  - All other instructions: one cycle, then EXEC2.
  - I-type ALU ops and stores also drive `src_b_sel_o`=1 here.
- **DWAIT.**
  - Counts down the same way as IWAIT.
  - At counter 0, asserts `data_latch_en_o` for one cycle, then goes to EXEC2.
- **EXEC2.**
  - Stores (SW/SH/SB): drive `ram_write_en_o`=1, `ram_addr_sel_o`=1, `src_b_sel_o`=1, byte enables as for loads. Hold while `waitrequest_i`=1.
  - MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO: hold while `muldiv_busy_i`=1.
  - The exit cycle is the first cycle with no hold condition. `pc_write_en_o` and `regfile_write_en_o` assert only in the exit cycle (one pulse each).
  - Next state: HALT if `pc_next_zero_i`=1, else FETCH.
- **Register-file writes in the EXEC2 exit cycle.**
  - RD: R-type ALU/shift, MFHI/MFLO.
  - RD, gated by `b_cond_met_i`: JALR.
  - RT: loads, I-type ALU.
  - GPR31, gated by `b_cond_met_i`: JAL.
  - GPR31, unconditional: BGEZAL/BLTZAL.
  - Unknown opcode or function: no write; PC still advances.
- **HALT.** `active_o`=0 and all enables 0. Stays in HALT until `reset`.
- **Waitrequest outside a memory state.** Ignored.

Optional Feature:
- Macro: `MIPS_CPU_SEQ_PERF_EN`.
- Defined:
  - `cycle_count_o` increments every non-reset cycle with `active_o`=1.
  - `instr_count_o` increments on each EXEC2 exit.
  - Both clear on reset and saturate at 0xFFFFFFFF.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package `codes`:
  - Extended `state_t` (adds IWAIT, DWAIT, HALT).
  - Existing `opcode_t`, `func_t`, `regimm_t`, `regfile_addr_sel_t`.
  - New function `byte_en_for(opcode, offset)`.
- Sub-module `mips_cpu_read_latency_tracker`:
  - Inputs: start, `READ_LATENCY`.
  - Output: a done pulse.
  - Instanced once and shared by IWAIT and DWAIT.

Test Plan:
- **ADDU, no waitrequest, `READ_LATENCY`=1** -> states FETCH, IWAIT, EXEC1, EXEC2, FETCH. `ir_write_en_o` 1 cycle in IWAIT. In EXEC2: `regfile_write_en_o`=1 with sel RD, and `pc_write_en_o` 1 cycle.
- **`waitrequest_i` high 3 cycles in FETCH, `READ_LATENCY`=3** -> `ram_read_en_o` held 4 cycles. `ir_write_en_o` exactly once, 3 cycles after acceptance.
- **LB, offset 2** -> EXEC1 `ram_byte_en_o`=0100, `ram_addr_sel_o`=1. `data_latch_en_o` pulses once. EXEC2 writes RT.
- **SH, offset 2, `waitrequest_i` high 2 cycles in EXEC2** -> `ram_write_en_o` held 3 cycles with byte enables 1100. `pc_write_en_o` only in the third cycle.
- **MULT with `muldiv_busy_i` high 5 cycles; BLTZAL with `b_cond_met_i`=0** -> MULT stays 6 cycles in EXEC2. BLTZAL still writes GPR31.
- **JR with `pc_next_zero_i`=1** -> HALT, `active_o`=0, no further reads. Reset asserted mid-DWAIT -> FETCH next cycle, no `data_latch_en_o`.
